// File: rtl/ssp_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_cfg_arbiter_if
//  Brief    : Requester-side and ssp_uart-side signals of the configuration
//             port arbiter. The slave modport is the arbiter's view; the
//             master modport is the view of the surrounding environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface ssp_cfg_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 10
);
    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rd_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    // ssp_uart configuration port side
    logic                      cfg_enable;
    logic                      cfg_rd_wr;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [DATA_W-1:0]         cfg_wdata;
    logic [DATA_W-1:0]         cfg_rdata;

    // Status
    logic                      busy;

    modport slave (
        input  req_valid, req_rd_wr, req_addr, req_wdata, cfg_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata, busy
    );

    modport master (
        output req_valid, req_rd_wr, req_addr, req_wdata, cfg_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/ssp_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_cfg_arbiter
//  Brief    : Round-robin arbiter and access sequencer sharing the single
//             ssp_uart configuration port between NUM_REQ requesters.
//             Each grant produces ACCESS_CYCLES cycles of cfg_enable followed
//             by a one-cycle completion pulse to the granted requester.
//  Revision : 1.0 - initial release
// ============================================================================
module ssp_cfg_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 10,
    parameter int ACCESS_CYCLES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ssp_cfg_arbiter_if.slave     bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [PTR_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [PTR_W-1:0]    r_win;
    logic                r_rd_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any;
    logic [PTR_W-1:0]    w_win;
    logic                w_sel_rd_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_last;

    assign w_last = (r_cnt == C_CNT_LAST);

    // Round-robin search: first pending requester at or above rr_ptr, with wrap
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && bus.req_valid[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
    end

    // Multiplex the winning requester's command fields for the grant latch
    always_comb begin
        w_sel_rd_wr = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_sel_rd_wr = bus.req_rd_wr[i];
                w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and all outputs, decoded from registered state only
    always_comb begin
        w_state_nxt    = r_state;
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.rsp_rdata  = r_rdata;
        bus.cfg_enable = 1'b0;
        bus.cfg_rd_wr  = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
        bus.busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.cfg_enable = 1'b1;
                bus.cfg_rd_wr  = r_rd_wr;
                bus.cfg_addr   = r_addr;
                bus.cfg_wdata  = r_wdata;
                // Accept pulse lands in the first access cycle only
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.req_ready[i] = (r_cnt == '0) && (r_win == PTR_W'(i));
                end
                if (w_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.rsp_valid[i] = (r_win == PTR_W'(i));
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant latch, round-robin pointer, access counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_win    <= '0;
            r_rd_wr  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win    <= w_win;
                        r_rd_wr  <= w_sel_rd_wr;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_cnt    <= '0;
                        r_rr_ptr <= (w_win == C_PTR_LAST) ? '0 : (w_win + PTR_W'(1));
                    end
                end
                S_ACCESS: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        // Writes report zero so rsp_rdata never carries stale read data
                        r_rdata <= r_rd_wr ? bus.cfg_rdata : '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssp_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssp_cfg_arbiter
//  Brief    : Directed self-checking bench for ssp_cfg_arbiter with a
//             response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssp_cfg_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 10;
    localparam int AC      = 2;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    int   gq[$];

    ssp_cfg_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ssp_cfg_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One complete transaction from a single requester, checked cycle by cycle
    task automatic do_txn(input int idx, input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rd_val,
                          input bit chg_addr);
        exp_t e;
        int   lat;
        @(posedge clk); #1;
        bus.req_valid[idx]                 = 1'b1;
        bus.req_rd_wr[idx]                 = rw;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = addr;
        bus.req_wdata[idx*DATA_W +: DATA_W] = wdata;
        bus.cfg_rdata                      = ~rd_val;
        e.idx   = idx;
        e.rdata = rw ? rd_val : '0;
        sb.push_back(e);
        @(negedge clk);
        chk("c0_busy", 32'(bus.busy), 0);
        chk("c0_ready", 32'(bus.req_ready), 0);
        for (int c = 1; c <= AC; c++) begin
            @(posedge clk); #1;
            bus.req_valid[idx] = 1'b0;
            if (chg_addr) bus.req_addr[idx*ADDR_W +: ADDR_W] = 3'h7;
            bus.cfg_rdata = (c == AC) ? rd_val : ~rd_val;
            @(negedge clk);
            chk("acc_en", 32'(bus.cfg_enable), 1);
            chk("acc_addr", 32'(bus.cfg_addr), 32'(addr));
            chk("acc_wdata", 32'(bus.cfg_wdata), 32'(wdata));
            chk("acc_rw", 32'(bus.cfg_rd_wr), 32'(rw));
            chk("acc_ready", 32'(bus.req_ready), (c == 1) ? (32'd1 << idx) : 32'd0);
            chk("acc_rsp", 32'(bus.rsp_valid), 0);
            chk("acc_busy", 32'(bus.busy), 1);
        end
        lat = AC;
        do begin
            @(posedge clk); #1;
            bus.cfg_rdata = ~rd_val;
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid == '0 && lat < AC + 8);
        chk("rsp_latency", 32'(lat), 32'(AC + 1));
        if (bus.rsp_valid != '0 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.idx);
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            chk("rsp_cfg_en", 32'(bus.cfg_enable), 0);
            chk("rsp_cfg_addr", 32'(bus.cfg_addr), 0);
            chk("rsp_busy", 32'(bus.busy), 1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_busy", 32'(bus.busy), 0);
        chk("post_rsp", 32'(bus.rsp_valid), 0);
        chk("post_hold", 32'(bus.rsp_rdata), 32'(e.rdata));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int g;
        int grants;
        int last_cyc;
        logic prev_en;
        n_pass  = 0;
        n_total = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_rd_wr = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.cfg_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_en", 32'(bus.cfg_enable), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp", 32'(bus.rsp_valid), 0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_addr", 32'(bus.cfg_addr), 0);
        #1 rst = 1'b0;

        // Basic writes, a read with late cfg_rdata, and address change mid-access
        do_txn(0, 1'b0, 3'h0, 10'h001, 10'h000, 1'b0);
        do_txn(1, 1'b0, 3'h3, 10'h003, 10'h000, 1'b0);
        do_txn(0, 1'b1, 3'h5, 10'h000, 10'h2A5, 1'b0);
        @(negedge clk);
        chk("read_hold", 32'(bus.rsp_rdata), 32'h2A5);
        do_txn(0, 1'b0, 3'h2, 10'h155, 10'h000, 1'b1);

        // Fairness: both requesters held valid for four grants
        apply_reset();
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        bus.req_rd_wr = 2'b00;
        bus.req_addr  = {3'h4, 3'h1};
        bus.req_wdata = {10'h0AA, 10'h055};
        grants   = 0;
        last_cyc = 0;
        prev_en  = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g = gq.pop_front();
                chk("rr_order", 32'(bus.req_ready), 32'd1 << g);
                chk("rr_no_overlap", 32'(prev_en), 0);
                if (grants > 0) chk("rr_spacing", 32'(cyc - last_cyc), 4);
                last_cyc = cyc;
                grants++;
                if (grants == 4) bus.req_valid = '0;
            end
            prev_en = bus.cfg_enable;
        end
        chk("rr_grants", 32'(grants), 4);
        repeat (6) @(posedge clk);

        // Reset during the second access cycle of a req1 write
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b1;
        bus.req_rd_wr[1] = 1'b0;
        bus.req_addr[ADDR_W +: ADDR_W]  = 3'h3;
        bus.req_wdata[DATA_W +: DATA_W] = 10'h003;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_en", 32'(bus.cfg_enable), 1);
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_en", 32'(bus.cfg_enable), 0);
        chk("mrst_rsp", 32'(bus.rsp_valid), 0);
        chk("mrst_addr", 32'(bus.cfg_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wins_busy", 32'(bus.busy), 0);
        chk("rst_wins_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("post_rst_first", 32'(bus.req_ready), 32'd1);
        repeat (6) @(posedge clk);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
